signed_bcd_seq: RTL and testbench
=================================

# signed_bcd_seq

Sequential converter from a 32-bit two's-complement result to sign plus seven BCD digits for the seven-segment display stage. It accepts one value per valid/ready handshake. It converts the magnitude with a multi-cycle shift-and-add-3 (double-dabble) loop, then holds the sign, digits and overflow flag stable for the per-digit display decoders. It replaces the purely combinational conversion path, which does not close timing at the board clock.

## Interface
- IN_W, 32, input width in bits; legal range 8..32; internal BCD stage always sized for 10 digits.
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is presented this cycle.
- in_data  input  IN_W  two's-complement value.
- in_ready  output  1  converter idle and able to accept.
- out_valid  output  1  one-cycle pulse: new sign/digits/overflow are loaded.
- sign  output  1  1 = value negative; drives the minus-segment digit.
- d0..d6  output  4 each  BCD digits; d0 = units, d6 = millions.
- overflow  output  1  |value| > 9,999,999.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, capture sign = in_data[IN_W-1] and magnitude = sign ? -in_data : in_data, as an IN_W-bit unsigned value.
  - Clear the 40-bit BCD accumulator and the iteration counter; go to SHIFT.
- SHIFT, one iteration per cycle:
  - Add 3 to every BCD nibble that is ≥ 5.
  - Shift {bcd, magnitude} left by one.
  - After IN_W iterations, go to DONE.
- DONE:
  - Load output registers.
  - overflow = any of BCD digits 7..9 nonzero.
  - Pulse out_valid.
  - Return to IDLE.
- Magnitude arithmetic:
  - -2^(IN_W-1) gives an unsigned magnitude of 2^(IN_W-1), with no wrap; for IN_W = 32 this is 2,147,483,648.
  - Zero always yields sign = 0.
- Outputs hold their last loaded values until the next DONE.
- in_valid while not in IDLE is ignored; there is no queuing.
- Reset values: state IDLE, sign 0, d0..d6 0, overflow 0, out_valid 0, in_ready 1.
- Reset mid-conversion aborts the conversion. The output registers are cleared and no out_valid is produced.

## Timing
- Accept edge E0 (in_valid & in_ready).
- Edges E1..E(IN_W) perform the shift iterations.
- Edge E(IN_W+1) loads the outputs and asserts out_valid.
- out_valid is high for exactly one cycle.
- in_ready is 0 from after E0 until after E(IN_W+1).
- Earliest next accept is edge E(IN_W+2), giving a throughput of one conversion per IN_W+2 cycles (34 at default).
- Outputs never change except at the DONE edge or under reset, so the display sees no glitches.

## Configuration
- SIGNED_BCD_SATURATE_EN:
  - Defined: when overflow = 1, d6..d0 are forced to 9,999,999.
  - Undefined: d6..d0 are the low seven decimal digits of the magnitude (magnitude mod 10^7).
  - overflow and sign behave identically in both builds.

## Structure
- Shared package bcd_pkg:
  - State enum {IDLE, SHIFT, DONE}.
  - NUM_DISP_DIGITS = 7.
  - NUM_BCD_DIGITS = 10.
  - BCD_MAX_DISP = 28'h9999999.
- One sub-module, bcd_add3: combinational 4-bit nibble correction (≥5 → +3). It is instantiated 10 times inside the SHIFT datapath.
- Counter width is $clog2(IN_W+1).

## Test plan
- Input 0 -> after 34 cycles out_valid pulse; sign 0; d6..d0 = 0000000; overflow 0.
- Input 12345 -> d6..d0 = 0012345, sign 0, overflow 0.
- Input -1 (32'hFFFFFFFF) -> sign 1, d6..d0 = 0000001.
- Input 10,000,000 -> overflow 1.
  - d6..d0 = 9999999 with SIGNED_BCD_SATURATE_EN.
  - d6..d0 = 0000000 without it.
- Input 32'h80000000 -> sign 1, overflow 1.
  - d6..d0 = 9999999 with the macro.
  - d6..d0 = 7483648 without it.
- Mid-operation events:
  - Accept 999, assert rst at iteration 10 -> all outputs 0, no out_valid, in_ready 1 after reset.
  - in_valid held high with changing data during a conversion -> only the first value is converted.
  - Back-to-back accept is possible at cycle 35.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the signed binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int NUM_DISP_DIGITS = 7;
    localparam int NUM_BCD_DIGITS  = 10;

    localparam logic [NUM_DISP_DIGITS*4-1:0] BCD_MAX_DISP = 28'h9999999;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: digits of 5 or more get +3 before the shift.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/signed_bcd_seq.sv
// Sequential signed binary to sign + 7-digit BCD converter (iterative double-dabble).
// Build option: SIGNED_BCD_SATURATE_EN clamps the displayed digits to 9999999 on overflow.
module signed_bcd_seq
    import bcd_pkg::*;
#(
    parameter int IN_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic            sign,
    output logic [3:0]      d0,
    output logic [3:0]      d1,
    output logic [3:0]      d2,
    output logic [3:0]      d3,
    output logic [3:0]      d4,
    output logic [3:0]      d5,
    output logic [3:0]      d6,
    output logic            overflow
);

    localparam int CNT_W  = $clog2(IN_W + 1);
    localparam int BCD_W  = NUM_BCD_DIGITS * 4;
    localparam int DISP_W = NUM_DISP_DIGITS * 4;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SHIFT = SHIFT;
    localparam logic [1:0] S_DONE  = DONE;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(IN_W - 1);

    logic [1:0]        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [BCD_W-1:0]  bcd_reg;
    logic [BCD_W-1:0]  bcd_adj;
    logic [IN_W-1:0]   mag_reg;
    logic [IN_W-1:0]   mag_next;
    logic              sign_cap_reg;

    logic              out_valid_reg;
    logic              sign_reg;
    logic              overflow_reg;
    logic              overflow_next;
    logic [DISP_W-1:0] digits_reg;
    logic [DISP_W-1:0] digits_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BCD_DIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .din  (bcd_reg[gi*4 +: 4]),
                .dout (bcd_adj[gi*4 +: 4])
            );
        end
    endgenerate

    // Unsigned IN_W-bit negate: the most negative input maps to 2^(IN_W-1) without wrapping.
    always_comb begin
        mag_next = in_data;
        if (in_data[IN_W-1]) begin
            mag_next = ~in_data + IN_W'(1);
        end
    end

    always_comb begin
        overflow_next = |bcd_reg[BCD_W-1:DISP_W];
`ifdef SIGNED_BCD_SATURATE_EN
        digits_next = overflow_next ? BCD_MAX_DISP : bcd_reg[DISP_W-1:0];
`else
        digits_next = bcd_reg[DISP_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            bcd_reg       <= '0;
            mag_reg       <= '0;
            sign_cap_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            sign_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            digits_reg    <= '0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        sign_cap_reg <= in_data[IN_W-1];
                        mag_reg      <= mag_next;
                        bcd_reg      <= '0;
                        cnt_reg      <= '0;
                        state_reg    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Correct every nibble, then shift the next magnitude bit into the BCD LSB.
                    bcd_reg <= (bcd_adj << 1) | {{(BCD_W-1){1'b0}}, mag_reg[IN_W-1]};
                    mag_reg <= mag_reg << 1;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_ITER) begin
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    sign_reg      <= sign_cap_reg;
                    overflow_reg  <= overflow_next;
                    digits_reg    <= digits_next;
                    out_valid_reg <= 1'b1;
                    state_reg     <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == S_IDLE);
    assign out_valid = out_valid_reg;
    assign sign      = sign_reg;
    assign overflow  = overflow_reg;
    assign d0        = digits_reg[3:0];
    assign d1        = digits_reg[7:4];
    assign d2        = digits_reg[11:8];
    assign d3        = digits_reg[15:12];
    assign d4        = digits_reg[19:16];
    assign d5        = digits_reg[23:20];
    assign d6        = digits_reg[27:24];

endmodule

// File: tb/tb_signed_bcd_seq.sv
// Randomized self-checking bench for signed_bcd_seq against a decimal arithmetic model.
// Honours SIGNED_BCD_SATURATE_EN the same way the design does.
module tb_signed_bcd_seq;

    localparam int IN_W = 32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        sign;
    logic [3:0]  d0, d1, d2, d3, d4, d5, d6;
    logic        overflow;

    int checks;
    int failures;

    signed_bcd_seq #(.IN_W(IN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .sign      (sign),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .d4        (d4),
        .d5        (d5),
        .d6        (d6),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] digits_obs();
        return {d6, d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed arithmetic and decimal division.
    function automatic void model(input logic [31:0] v, output logic s,
                                  output logic [27:0] dig, output logic o);
        longint sv;
        longint mag;
        longint m;
        sv  = longint'($signed(v));
        mag = (sv < 0) ? -sv : sv;
        s   = (sv < 0);
        o   = (mag > 64'd9999999);
        m   = mag % 10000000;
`ifdef SIGNED_BCD_SATURATE_EN
        if (o) m = 9999999;
`endif
        dig = '0;
        for (int i = 0; i < 7; i++) begin
            dig[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
    endfunction

    // Runs one conversion; caller is at a negedge. junk=1 keeps in_valid high with random data.
    task automatic do_conv(input logic [31:0] v, input bit junk);
        logic        exp_s;
        logic        exp_o;
        logic [27:0] exp_d;
        logic [29:0] snap;
        int          n;
        int          w;
        bit          got;
        bit          ready_err;
        bit          hold_err;

        model(v, exp_s, exp_d, exp_o);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_accept", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk);
        @(negedge clk);
        check("pulse_width", out_valid, 1'b0);
        check("ready_low_after_accept", in_ready, 1'b0);
        snap = {sign, overflow, digits_obs()};
        if (junk) in_data = $urandom;
        else      in_valid = 1'b0;

        n = 0;
        got = 0;
        ready_err = 0;
        hold_err = 0;
        while (n < IN_W + 8 && !got) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (out_valid) begin
                got = 1;
            end else begin
                if (in_ready) ready_err = 1;
                if ({sign, overflow, digits_obs()} !== snap) hold_err = 1;
                if (junk) in_data = $urandom;
            end
        end
        in_valid = 1'b0;

        check("out_valid_seen", got, 1'b1);
        check("latency", n, IN_W + 1);
        check("ready_low_during_conv", ready_err, 1'b0);
        check("outputs_held", hold_err, 1'b0);
        check("sign", sign, exp_s);
        check("digits", digits_obs(), exp_d);
        check("overflow", overflow, exp_o);
        check("ready_at_done", in_ready, 1'b1);
        $display("conv in=%08h junk=%0d sign=%0d digits=%07h ovf=%0d latency=%0d",
                 v, junk, sign, digits_obs(), overflow, n);
    endtask

    initial begin
        logic [31:0] v;
        bit          seen;
        logic [31:0] fixed [9];

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sign", sign, 1'b0);
        check("rst_digits", digits_obs(), 28'h0);
        check("rst_overflow", overflow, 1'b0);

        fixed[0] = 32'd0;
        fixed[1] = 32'd12345;
        fixed[2] = 32'hFFFFFFFF;
        fixed[3] = 32'd10000000;
        fixed[4] = 32'h80000000;
        fixed[5] = 32'd9999999;
        fixed[6] = -32'sd9999999;
        fixed[7] = -32'sd10000000;
        fixed[8] = 32'h7FFFFFFF;
        // Back-to-back: each call accepts on the first edge after the previous out_valid.
        for (int i = 0; i < 9; i++) do_conv(fixed[i], 1'b0);

        for (int i = 0; i < 24; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = -v;
            do_conv(v, bit'(i % 3 == 0));
        end

        // Reset mid-conversion: outputs from the previous conversion must clear, no pulse.
        do_conv(32'd4321, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'd999;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_sign", sign, 1'b0);
        check("abort_digits", digits_obs(), 28'h0);
        check("abort_overflow", overflow, 1'b0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("abort_no_valid", seen, 1'b0);
        $display("reset_abort in=000003e7 ready=%0d digits=%07h", in_ready, digits_obs());

        do_conv(32'd999, 1'b0);
        do_conv(-32'sd999, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
